// File: rtl/fix_msg_tx.sv
// fix_msg_tx: byte-serial FIX message transmitter.
// Builds "8=FIX.4.<m>;9=<len>;35=<T>;34=<seq>;[98=0;108=<hb>;]10=<ccc>;"
// on each accepted start pulse and streams it out under valid/ready.
// Optional build macro FIX_TX_AUTOSEQ_EN: MsgSeqNum comes from an internal
// counter (reset value 1, +1 per message, 65535 wraps to 1), not seq_num.
module fix_msg_tx #(
  parameter logic [7:0] DELIM     = 8'h3B,
  parameter logic [7:0] FIX_MINOR = 8'h34
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  msg_type,
  input  logic [15:0] seq_num,
  input  logic [7:0]  hb_int,
  output logic [7:0]  dout,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_SEND} state_e;
  // Message fields in transmit order; SEG_RESET/SEG_HB exist only for Logon.
  typedef enum logic [2:0] {
    SEG_BEGIN, SEG_LEN, SEG_TYPE, SEG_SEQ, SEG_RESET, SEG_HB, SEG_CHK
  } seg_e;

  state_e      state_q, state_d;
  seg_e        seg_q, seg_d;
  logic [3:0]  pos_q, pos_d;
  logic [7:0]  type_q, type_d;
  logic        logon_q, logon_d;
  logic [15:0] seq_bin_q, seq_bin_d;
  logic [7:0]  hb_bin_q, hb_bin_d;
  logic [19:0] seq_bcd_q, seq_bcd_d;
  logic [11:0] hb_bcd_q, hb_bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  ds_q, ds_d;
  logic [1:0]  dh_q, dh_d;
  logic [4:0]  bl_q, bl_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [19:0] seq_adj, hb_adj;
  logic [2:0]  ds_c;
  logic [1:0]  dh_c;
  logic        last_c;
`ifdef FIX_TX_AUTOSEQ_EN
  logic [15:0] seq_cnt_q, seq_cnt_d;
`endif

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
  function automatic logic [19:0] dd_adjust(logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // ASCII character of BCD digit k (0 = least significant).
  function automatic logic [7:0] digit_char(logic [19:0] b, logic [3:0] k);
    logic [3:0] n;
    case (k)
      4'd0:    n = b[3:0];
      4'd1:    n = b[7:4];
      4'd2:    n = b[11:8];
      4'd3:    n = b[15:12];
      4'd4:    n = b[19:16];
      default: n = 4'd0;
    endcase
    return 8'h30 + {4'd0, n};
  endfunction

  // Index of the final (DELIM) byte of each segment.
  function automatic logic [3:0] seg_last(seg_e seg, logic [2:0] ds, logic [1:0] dh);
    case (seg)
      SEG_BEGIN: return 4'd9;
      SEG_SEQ:   return 4'd3 + {1'b0, ds};
      SEG_HB:    return 4'd4 + {2'b0, dh};
      SEG_CHK:   return 4'd6;
      default:   return 4'd4;
    endcase
  endfunction

  // Byte at position pos of segment seg; numbers are printed MSD first.
  function automatic logic [7:0] msg_byte(seg_e seg, logic [3:0] pos, logic [2:0] ds,
                                          logic [1:0] dh, logic [4:0] bl, logic [7:0] mtype,
                                          logic [7:0] acc, logic [19:0] sbcd, logic [11:0] hbcd);
    logic [7:0] b;
    b = DELIM;
    case (seg)
      SEG_BEGIN: case (pos)
        4'd0: b = "8";  4'd1: b = "=";  4'd2: b = "F";  4'd3: b = "I";
        4'd4: b = "X";  4'd5: b = ".";  4'd6: b = "4";  4'd7: b = ".";
        4'd8: b = FIX_MINOR;
        default: b = DELIM;
      endcase
      SEG_LEN: case (pos)
        4'd0: b = "9";  4'd1: b = "=";
        4'd2: b = 8'h30 + {3'd0, bl / 5'd10};
        4'd3: b = 8'h30 + {3'd0, bl % 5'd10};
        default: b = DELIM;
      endcase
      SEG_TYPE: case (pos)
        4'd0: b = "3";  4'd1: b = "5";  4'd2: b = "=";  4'd3: b = mtype;
        default: b = DELIM;
      endcase
      SEG_SEQ: case (pos)
        4'd0: b = "3";  4'd1: b = "4";  4'd2: b = "=";
        default:
          if (pos < {1'b0, ds} + 4'd3) b = digit_char(sbcd, {1'b0, ds} + 4'd2 - pos);
      endcase
      SEG_RESET: case (pos)
        4'd0: b = "9";  4'd1: b = "8";  4'd2: b = "=";  4'd3: b = "0";
        default: b = DELIM;
      endcase
      SEG_HB: case (pos)
        4'd0: b = "1";  4'd1: b = "0";  4'd2: b = "8";  4'd3: b = "=";
        default:
          if (pos < {2'b0, dh} + 4'd4) b = digit_char({8'd0, hbcd}, {2'b0, dh} + 4'd3 - pos);
      endcase
      SEG_CHK: case (pos)
        4'd0: b = "1";  4'd1: b = "0";  4'd2: b = "=";
        4'd3: b = 8'h30 + acc / 8'd100;
        4'd4: b = 8'h30 + (acc / 8'd10) % 8'd10;
        4'd5: b = 8'h30 + acc % 8'd10;
        default: b = DELIM;
      endcase
      default: b = DELIM;
    endcase
    return b;
  endfunction

  // Next-state, datapath and handshake logic.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d   = state_q;   seg_d     = seg_q;     pos_d    = pos_q;
    type_d    = type_q;    logon_d   = logon_q;
    seq_bin_d = seq_bin_q; hb_bin_d  = hb_bin_q;
    seq_bcd_d = seq_bcd_q; hb_bcd_d  = hb_bcd_q;
    cnt_d     = cnt_q;     ds_d      = ds_q;      dh_d     = dh_q;   bl_d = bl_q;
    acc_d     = acc_q;     dout_d    = dout_q;    valid_d  = valid_q;
    busy_d    = busy_q;    done_d    = 1'b0;
    seq_adj   = dd_adjust(seq_bcd_q);
    hb_adj    = dd_adjust({8'd0, hb_bcd_q});
    ds_c      = (seq_bcd_q[19:16] != 4'd0) ? 3'd5 :
                (seq_bcd_q[15:12] != 4'd0) ? 3'd4 :
                (seq_bcd_q[11:8]  != 4'd0) ? 3'd3 :
                (seq_bcd_q[7:4]   != 4'd0) ? 3'd2 : 3'd1;
    dh_c      = (hb_bcd_q[11:8] != 4'd0) ? 2'd3 :
                (hb_bcd_q[7:4]  != 4'd0) ? 2'd2 : 2'd1;
    last_c    = (pos_q == seg_last(seg_q, ds_q, dh_q));
`ifdef FIX_TX_AUTOSEQ_EN
    seq_cnt_d = seq_cnt_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        type_d    = msg_type;
        logon_d   = (msg_type == 8'h41);
`ifdef FIX_TX_AUTOSEQ_EN
        seq_bin_d = seq_cnt_q;
`else
        seq_bin_d = seq_num;
`endif
        hb_bin_d  = hb_int;
        seq_bcd_d = '0;
        hb_bcd_d  = '0;
        cnt_d     = '0;
        acc_d     = '0;
        busy_d    = 1'b1;
        state_d   = S_PREP;
      end
      S_PREP: if (!cnt_q[4]) begin
        // 16 shifts for seq; hb joins for the last 8 so both finish together.
        seq_bcd_d = {seq_adj[18:0], seq_bin_q[15]};
        seq_bin_d = {seq_bin_q[14:0], 1'b0};
        if (cnt_q[3]) begin
          hb_bcd_d = {hb_adj[10:0], hb_bin_q[7]};
          hb_bin_d = {hb_bin_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
      end else begin
        ds_d    = ds_c;
        dh_d    = dh_c;
        bl_d    = logon_q ? 5'd19 + {2'd0, ds_c} + {3'd0, dh_c} : 5'd9 + {2'd0, ds_c};
        seg_d   = SEG_BEGIN;
        pos_d   = '0;
        dout_d  = "8";
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: if (valid_q && ready) begin
        if (seg_q != SEG_CHK) acc_d = acc_q + dout_q;
        if (seg_q == SEG_CHK && last_c) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dout_d  = '0;
          state_d = S_IDLE;
`ifdef FIX_TX_AUTOSEQ_EN
          seq_cnt_d = (seq_cnt_q == 16'hFFFF) ? 16'd1 : seq_cnt_q + 16'd1;
`endif
        end else begin
          if (last_c) begin
            pos_d = '0;
            seg_d = (seg_q == SEG_SEQ && !logon_q) ? SEG_CHK : seg_e'(seg_q + 3'd1);
          end else begin
            pos_d = pos_q + 4'd1;
          end
          dout_d = msg_byte(seg_d, pos_d, ds_q, dh_q, bl_q, type_q, acc_q, seq_bcd_q, hb_bcd_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  seg_q <= SEG_BEGIN;  pos_q <= '0;
      type_q <= '0;  logon_q <= 1'b0;  seq_bin_q <= '0;  hb_bin_q <= '0;
      seq_bcd_q <= '0;  hb_bcd_q <= '0;  cnt_q <= '0;
      ds_q <= 3'd1;  dh_q <= 2'd1;  bl_q <= '0;  acc_q <= '0;
      dout_q <= '0;  valid_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;  seg_q <= seg_d;  pos_q <= pos_d;
      type_q <= type_d;  logon_q <= logon_d;  seq_bin_q <= seq_bin_d;  hb_bin_q <= hb_bin_d;
      seq_bcd_q <= seq_bcd_d;  hb_bcd_q <= hb_bcd_d;  cnt_q <= cnt_d;
      ds_q <= ds_d;  dh_q <= dh_d;  bl_q <= bl_d;  acc_q <= acc_d;
      dout_q <= dout_d;  valid_q <= valid_d;  busy_q <= busy_d;  done_q <= done_d;
    end
  end

`ifdef FIX_TX_AUTOSEQ_EN
  // Automatic MsgSeqNum counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seq_cnt_q <= 16'd1;
    else          seq_cnt_q <= seq_cnt_d;
  end
`endif

  assign dout  = dout_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fix_msg_tx.sv
// tb_fix_msg_tx: randomized self-checking bench for fix_msg_tx with a
// string-level reference model of the FIX message.
module tb_fix_msg_tx;

`ifdef FIX_TX_AUTOSEQ_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam string HB1 = "8=FIX.4.4;9=10;35=0;34=1;10=141;";

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  msg_type = 8'h30;
  logic [15:0] seq_num = '0;
  logic [7:0]  hb_int = '0;
  logic [7:0]  dout;
  logic        valid;
  logic        ready = 1'b0;
  logic        busy;
  logic        done;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  string       cap = "";
  bit          in_reset = 1'b1;
  int          ready_mode = 0;
  int          model_seq = 1;

  always #5 clk = ~clk;

  fix_msg_tx dut (
    .clk(clk), .reset_n(reset_n), .start(start), .msg_type(msg_type),
    .seq_num(seq_num), .hb_int(hb_int), .dout(dout), .valid(valid),
    .ready(ready), .busy(busy), .done(done)
  );

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Reference message assembled field by field from the protocol rules.
  function automatic string build_msg(logic [7:0] t, int seq, int hb);
    string body, s;
    int sum;
    logic [7:0] c;
    body = $sformatf("35=%c;34=%0d;", t, seq);
    if (t == 8'h41) body = {body, $sformatf("98=0;108=%0d;", hb)};
    s = $sformatf("8=FIX.4.4;9=%0d;%s", body.len(), body);
    sum = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      sum += c;
    end
    return {s, $sformatf("10=%03d;", sum % 256)};
  endfunction

  function automatic logic [7:0] rand_type();
    case ($urandom_range(0, 2))
      0:       return 8'h30;
      1:       return 8'h41;
      default: return 8'($urandom_range(8'h21, 8'h7E));
    endcase
  endfunction

  // Ready driver: always-on or pseudo-random backpressure.
  initial forever begin
    @(posedge clk);
    #1;
    ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Per-cycle compare process: bytes, stall stability, valid continuity, done pulse.
  initial begin
    bit         p_valid, p_ready, p_final;
    logic [7:0] p_dout;
    p_valid = 0; p_ready = 0; p_final = 0; p_dout = '0;
    forever begin
      @(negedge clk);
      if (in_reset || !reset_n) begin
        p_valid = 0; p_ready = 0; p_final = 0;
      end else begin
        check_val("done_pulse", done, p_final);
        if (p_valid && !p_final) check_val("valid_hold", valid, 1);
        if (p_valid && !p_ready) check_val("dout_stall", dout, p_dout);
        p_final = 0;
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0d expected none", dout);
          end else begin
            check_val("dout", dout, exp_q.pop_front());
            cap = {cap, $sformatf("%c", dout)};
            p_final = (exp_q.size() == 0);
          end
        end
        p_valid = valid; p_ready = ready; p_dout = dout;
      end
    end
  end

  // Load one expected message and launch it; caller is at posedge+1.
  task automatic launch(input logic [7:0] t, input logic [15:0] s, input logic [7:0] h);
    string m;
    m = build_msg(t, AUTO ? model_seq : int'(s), int'(h));
    for (int i = 0; i < m.len(); i++) exp_q.push_back(m[i]);
    cap = "";
    msg_type = t; seq_num = s; hb_int = h; start = 1'b1;
  endtask

  // Send one message: latency, completion, drained queue, optional literal.
  task automatic send(input logic [7:0] t, input logic [15:0] s, input logic [7:0] h,
                      input int hold, input string lit);
    bit seen;
    launch(t, s, h);
    @(posedge clk); #1;
    if (hold == 0) start = 1'b0;
    check_val("busy_after_start", busy, 1);
    msg_type = rand_type(); seq_num = 16'($urandom); hb_int = 8'($urandom);
    repeat (16) @(posedge clk);
    #1;
    check_val("valid_before_17", valid, 0);
    @(posedge clk); #1;
    check_val("valid_at_17", valid, 1);
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (i == hold) start = 1'b0;
      if (done) seen = 1;
    end
    check_val("done_seen", seen, 1);
    check_val("busy_at_done", busy, 0);
    check_val("queue_drained", exp_q.size(), 0);
    if (lit != "") check_str("message", cap, lit);
    model_seq = (model_seq == 65535) ? 1 : model_seq + 1;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_dout", dout, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    reset_n = 1'b1;
    in_reset = 1'b0;
    @(posedge clk); #1;

`ifdef FIX_TX_AUTOSEQ_EN
    send(8'h30, 16'd999, 8'd0, 0, "8=FIX.4.4;9=10;35=0;34=1;10=141;");
    send(8'h30, 16'd999, 8'd0, 0, "8=FIX.4.4;9=10;35=0;34=2;10=142;");
    send(8'h30, 16'd999, 8'd0, 0, "8=FIX.4.4;9=10;35=0;34=3;10=143;");
`endif

    // Heartbeat and Logon with full-rate ready.
    send(8'h30, 16'd1, 8'd0, 0, AUTO ? "" : HB1);
    send(8'h41, 16'd1, 8'd30, 0, AUTO ? "" : "8=FIX.4.4;9=22;35=A;34=1;98=0;108=30;10=046;");

    // Backpressure.
    ready_mode = 1;
    send(8'h30, 16'd1, 8'd0, 0, AUTO ? "" : HB1);
    ready_mode = 0;

    // Field-width boundaries.
    send(8'h30, 16'd0, 8'd0, 0, AUTO ? "" : "8=FIX.4.4;9=10;35=0;34=0;10=140;");
    send(8'h30, 16'd65535, 8'd0, 0, AUTO ? "" : "8=FIX.4.4;9=14;35=0;34=65535;10=104;");
    send(8'h41, 16'd65535, 8'd255, 0, "");
    send(8'h41, 16'd0, 8'd0, 0, "");

    // start held into SEND: exactly one message, then idle.
    send(8'h30, 16'd42, 8'd0, 10, "");
    repeat (30) @(posedge clk);
    #1;
    check_val("no_second_msg", busy, 0);

    // Reset in the middle of SEND aborts the message.
    launch(8'h30, 16'd7, 8'd0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    reset_n = 1'b0;
    in_reset = 1'b1;
    #1;
    check_val("abort_valid", valid, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    exp_q.delete();
    model_seq = 1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    in_reset = 1'b0;
    @(posedge clk); #1;
    send(8'h30, 16'd1, 8'd0, 0, HB1);

    // Randomized messages with random backpressure.
    for (int n = 0; n < 14; n++) begin
      ready_mode = $urandom_range(0, 1);
      send(rand_type(), 16'($urandom), 8'($urandom), 0, "");
    end
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
